fxp_div_seq: RTL and testbench



---
 rtl/fxp_div_seq.sv | 177 +++++++++++++++++
 tb/tb_fxp_div_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fxp_div_seq.sv
`default_nettype none
// ============================================================================
// fxp_div_seq : sequential signed fixed-point divider (restoring, 1 bit/clk)
// Rev 1.0
// ============================================================================
module fxp_div_seq #(
   parameter int A_width_int       = 8,
   parameter int A_width_frac      = 8,
   parameter int B_width_int       = 8,
   parameter int B_width_frac      = 8,
   parameter int output_width_int  = 8,
   parameter int output_width_frac = 8,
   parameter int ROUND             = 1
) (
   input  logic                                          clk,
   input  logic                                          rstn,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [A_width_int+A_width_frac-1:0]           ina,
   input  logic [B_width_int+B_width_frac-1:0]           inb,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [output_width_int+output_width_frac-1:0] out,
   output logic                                          overflow,
   output logic                                          div_by_zero
);

   localparam int AW = A_width_int + A_width_frac;
   localparam int BW = B_width_int + B_width_frac;
   localparam int OW = output_width_int + output_width_frac;
   localparam int SH = output_width_frac + B_width_frac - A_width_frac + ((ROUND != 0) ? 1 : 0);
   localparam int NW = AW + SH;
   localparam int LW = ((NW > OW) ? NW : OW) + 1;
   localparam int CW = $clog2(NW + 1);

   generate
      if (SH < 0) begin : g_bad_shift
         $error("fxp_div_seq: output_width_frac + B_width_frac + ROUND must be >= A_width_frac");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [NW-1:0]   r_num;
   logic [BW-1:0]   r_rem;
   logic [BW-1:0]   r_div;
   logic            r_neg;
   logic [CW-1:0]   r_cnt;
   logic [OW-1:0]   r_out;
   logic            r_ovf;
   logic            r_dbz;

   logic [AW-1:0]   w_amag;
   logic [BW-1:0]   w_bmag;
   logic            w_b_zero;
   logic [NW-1:0]   w_num_init;
   logic [BW:0]     w_trial;
   logic            w_ge;
   logic [BW-1:0]   w_sub;
   logic [NW-1:0]   w_qr;
   logic [LW-1:0]   w_qr_ext;
   logic [LW-1:0]   w_lim;
   logic            w_clip;
   logic [OW-1:0]   w_mag;
   logic [OW-1:0]   w_res;
   logic [OW-1:0]   w_dbz_val;

   // Magnitudes are unsigned, so the most-negative operand maps to 2^(W-1).
   assign w_amag     = ina[AW-1] ? -ina : ina;
   assign w_bmag     = inb[BW-1] ? -inb : inb;
   assign w_b_zero   = (inb == '0);
   assign w_num_init = NW'(w_amag) << SH;

   // Partial remainder is always below the divisor, so the low BW bits of the
   // difference are exact whenever the trial subtract succeeds.
   assign w_trial = {r_rem, r_num[NW-1]};
   assign w_ge    = w_trial[BW] | (w_trial[BW-1:0] >= r_div);
   assign w_sub   = w_trial[BW-1:0] - r_div;

   assign w_qr     = (ROUND != 0) ? NW'(({1'b0, r_num} + (NW+1)'(1)) >> 1) : r_num;
   assign w_qr_ext = LW'(w_qr);
   assign w_lim    = r_neg ? (LW'(1) << (OW-1)) : ((LW'(1) << (OW-1)) - LW'(1));
   assign w_clip   = (w_qr_ext > w_lim);
   assign w_mag    = w_clip ? w_lim[OW-1:0] : w_qr_ext[OW-1:0];
   assign w_res    = r_neg ? -w_mag : w_mag;

   assign w_dbz_val = (ina == '0) ? '0 :
                      ina[AW-1]   ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = w_b_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_num <= '0;
         r_rem <= '0;
         r_div <= '0;
         r_neg <= 1'b0;
         r_cnt <= '0;
         r_out <= '0;
         r_ovf <= 1'b0;
         r_dbz <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_num <= w_num_init;
                  r_rem <= '0;
                  r_div <= w_bmag;
                  r_neg <= ina[AW-1] ^ inb[BW-1];
                  r_cnt <= CW'(NW);
                  r_ovf <= w_b_zero;
                  r_dbz <= w_b_zero;
                  if (w_b_zero) begin
                     r_out <= w_dbz_val;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_sub : w_trial[BW-1:0];
               r_num <= {r_num[NW-2:0], w_ge};
               r_cnt <= r_cnt - CW'(1);
            end
            S_FIX: begin
               r_out <= w_res;
               r_ovf <= w_clip;
            end
            default: begin
            end
         endcase
      end
   end

   assign out         = r_out;
   assign overflow    = r_ovf;
   assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_fxp_div_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_fxp_div_seq : directed bench for fxp_div_seq (rounding and truncating)
// Rev 1.0
// ============================================================================
module tb_fxp_div_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] ina;
   logic [15:0] inb;

   logic        in_ready,   out_valid,   overflow,   div_by_zero;
   logic [15:0] out;
   logic        in_ready_t, out_valid_t, overflow_t, div_by_zero_t;
   logic [15:0] out_t;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fxp_div_seq #(.ROUND(1)) u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .overflow(overflow), .div_by_zero(div_by_zero)
   );

   fxp_div_seq #(.ROUND(0)) u_dut_t (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
      .ina(ina), .inb(inb), .out_valid(out_valid_t), .out_ready(out_ready),
      .out(out_t), .overflow(overflow_t), .div_by_zero(div_by_zero_t)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one operation to both instances, waits for both results, optionally
   // stalls the consumer for 'hold' cycles, then completes the handshake.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r_exp, input logic r_ov,
                         input logic [15:0] t_exp, input logic t_ov,
                         input logic dbz, input int hold);
      int          lat   = 0;
      int          lat_r = -1;
      int          lat_t = -1;
      logic        got_r = 1'b0, got_t = 1'b0;
      logic [15:0] o_r = '0, o_t = '0;
      logic        ov_r = 1'b0, ov_t = 1'b0, dz_r = 1'b0, dz_t = 1'b0;

      @(negedge clk);
      check({tag, ":in_ready"}, {in_ready, in_ready_t}, 2'b11);
      ina = a; inb = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      ina = 16'($urandom);
      inb = 16'($urandom);
      while (1) begin
         if (out_valid && !got_r) begin
            got_r = 1'b1; lat_r = lat; o_r = out; ov_r = overflow; dz_r = div_by_zero;
         end
         if (out_valid_t && !got_t) begin
            got_t = 1'b1; lat_t = lat; o_t = out_t; ov_t = overflow_t; dz_t = div_by_zero_t;
         end
         if ((got_r && got_t) || lat >= 60) break;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ":lat"},   lat_r, dbz ? 0 : 26);
      check({tag, ":lat_t"}, lat_t, dbz ? 0 : 25);
      check({tag, ":out"},   o_r,   r_exp);
      check({tag, ":ovf"},   ov_r,  r_ov);
      check({tag, ":dbz"},   dz_r,  dbz);
      check({tag, ":out_t"}, o_t,   t_exp);
      check({tag, ":ovf_t"}, ov_t,  t_ov);
      check({tag, ":dbz_t"}, dz_t,  dbz);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; ina = 16'h1234; inb = 16'h0100;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({tag, ":hold"}, {out_valid, in_ready, out, overflow}, {1'b1, 1'b0, r_exp, r_ov});
      end

      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":release"}, {out_valid, out_valid_t, in_ready, in_ready_t}, 4'b0011);
   endtask

   initial begin
      logic seen;
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ina = '0; inb = '0;
      repeat (3) @(negedge clk);
      check("reset", {in_ready, out_valid, overflow, div_by_zero, out}, {4'b1000, 16'h0000});
      check("reset_t", {in_ready_t, out_valid_t, overflow_t, div_by_zero_t, out_t}, {4'b1000, 16'h0000});
      rstn = 1'b1;

      //      tag         ina       inb       round    ov    trunc    ov    dbz  hold
      run_op("3/2",      16'h0300, 16'h0200, 16'h0180, 1'b0, 16'h0180, 1'b0, 1'b0, 0);
      run_op("-3/2",     16'hFD00, 16'h0200, 16'hFE80, 1'b0, 16'hFE80, 1'b0, 1'b0, 0);
      run_op("-128/1",   16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 0);
      run_op("2/3",      16'h0200, 16'h0300, 16'h00AB, 1'b0, 16'h00AA, 1'b0, 1'b0, 10);
      run_op("-2/3",     16'hFE00, 16'h0300, 16'hFF55, 1'b0, 16'hFF56, 1'b0, 1'b0, 0);
      run_op("100/.25",  16'h6400, 16'h0040, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 1'b0, 0);
      run_op("-100/.25", 16'h9C00, 16'h0040, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, 0);
      run_op("1/3",      16'h0100, 16'h0300, 16'h0055, 1'b0, 16'h0055, 1'b0, 1'b0, 0);
      run_op("max/-lsb", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, 0);
      run_op("0/3",      16'h0000, 16'h0300, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      run_op(".5/-1",    16'h0080, 16'hFF00, 16'hFF80, 1'b0, 16'hFF80, 1'b0, 1'b0, 0);
      run_op("half+",    16'h0001, 16'h0200, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      run_op("half-",    16'hFFFF, 16'h0200, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      run_op("min/min",  16'h8000, 16'h8000, 16'h0100, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
      run_op("-1/0",     16'hFF00, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1, 0);
      run_op("0/0",      16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 0);
      run_op("1/0",      16'h0100, 16'h0000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);

      // Abort a division mid-flight; the held 1/0 result must vanish at once.
      @(negedge clk);
      ina = 16'h0300; inb = 16'h0200; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check("rst_mid", {out_valid, in_ready, overflow, div_by_zero, out}, {4'b0100, 16'h0000});
      check("rst_mid_t", {out_valid_t, in_ready_t, overflow_t, div_by_zero_t, out_t}, {4'b0100, 16'h0000});
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid || out_valid_t) seen = 1'b1;
      end
      check("rst_no_result", seen, 1'b0);
      run_op("after_rst", 16'h0300, 16'h0200, 16'h0180, 1'b0, 16'h0180, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
